mem_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din`/`io_buffer_full` out). It implements the 128 KB unified RAM and the I/O window at `0x30000`. Behind the I/O window sit:
- a TX byte FIFO toward the UART transmitter;
- an RX byte FIFO from the UART receiver;
- a free-running cycle counter;
- a sticky program-stop flag.

It sits beside `cpu` at the SoC top.

---
 rtl/mem_io_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 128 KB RAM plus an I/O window at 0x30000 holding
// the UART TX/RX FIFOs, a free-running cycle counter and a sticky program-stop flag.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH       = 8,
  parameter int unsigned RX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int unsigned RamBytes = 1 << RAM_ADDR_WIDTH;
  localparam int unsigned TxAw     = $clog2(TX_DEPTH);
  localparam int unsigned TxPw     = TxAw + 1;
  localparam int unsigned RxAw     = $clog2(RX_DEPTH);
  localparam int unsigned RxPw     = RxAw + 1;

  // ---------------------------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------------------------
  logic [17:0] w_addr;
  logic        w_is_ram;
  logic        w_is_io;
  logic        w_io_data;
  logic        w_io_ctl;
  logic        w_io_snap1;
  logic        w_io_snap2;
  logic        w_io_snap3;
  logic        w_unused;

  assign w_addr     = mem_a[17:0];
  assign w_is_ram   = ~w_addr[17];
  assign w_is_io    = (w_addr[17:16] == 2'b11);
  assign w_io_data  = w_is_io && (w_addr[15:0] == 16'h0000);
  assign w_io_ctl   = w_is_io && (w_addr[15:0] == 16'h0004);
  assign w_io_snap1 = w_is_io && (w_addr[15:0] == 16'h0005);
  assign w_io_snap2 = w_is_io && (w_addr[15:0] == 16'h0006);
  assign w_io_snap3 = w_is_io && (w_addr[15:0] == 16'h0007);
  assign w_unused   = ^mem_a[31:18];

  // ---------------------------------------------------------------------------------------------
  // RAM (contents survive reset)
  // ---------------------------------------------------------------------------------------------
  logic [7:0] r_ram [0:RamBytes-1];
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
  logic       w_ram_we;

  assign w_ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];
  assign w_ram_we  = w_is_ram & mem_wr;

  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= mem_dout;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]      r_tx_mem [0:TX_DEPTH-1];
  logic [TxPw-1:0] r_tx_wptr;
  logic [TxPw-1:0] r_tx_rptr;
  logic [TxPw-1:0] w_tx_count;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic            w_tx_req;
  logic            w_tx_push;
  logic            w_tx_drop;
  logic            w_tx_pop;
  logic [7:0]      w_tx_wdata;

  assign w_tx_count = r_tx_wptr - r_tx_rptr;
  assign w_tx_full  = (w_tx_count == TxPw'(TX_DEPTH));
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  // A stop write enqueues the terminating NUL; data-port writes of 0x00 are discarded.
  assign w_tx_req   = mem_wr & ((w_io_data & (mem_dout != 8'h00)) | w_io_ctl);
  assign w_tx_push  = w_tx_req & ~w_tx_full;
  assign w_tx_drop  = w_tx_req & w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & tx_ready;
  assign w_tx_wdata = w_io_ctl ? 8'h00 : mem_dout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + TxPw'(1);
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + TxPw'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[TxAw-1:0]] <= w_tx_wdata;
    end
  end

  assign tx_valid       = ~w_tx_empty;
  assign tx_data        = r_tx_mem[r_tx_rptr[TxAw-1:0]];
  assign io_buffer_full = (w_tx_count >= TxPw'(TX_DEPTH - 2));

  // ---------------------------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]      r_rx_mem [0:RX_DEPTH-1];
  logic [RxPw-1:0] r_rx_wptr;
  logic [RxPw-1:0] r_rx_rptr;
  logic [RxPw-1:0] w_rx_count;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic            w_rx_push;
  logic            w_rx_pop;
  logic [7:0]      w_rx_head;

  assign w_rx_count = r_rx_wptr - r_rx_rptr;
  assign w_rx_full  = (w_rx_count == RxPw'(RX_DEPTH));
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_push  = rx_valid & ~w_rx_full;
  assign w_rx_pop   = w_io_data & ~mem_wr & ~w_rx_empty;
  assign w_rx_head  = r_rx_mem[r_rx_rptr[RxAw-1:0]];
  assign rx_ready   = ~w_rx_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wptr <= r_rx_wptr + RxPw'(1);
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + RxPw'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[RxAw-1:0]] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Cycle counter, snapshot and sticky flags
  // ---------------------------------------------------------------------------------------------
  logic [31:0] r_counter;
  logic [23:0] r_snap_hi;
  logic        r_program_done;
  logic        r_tx_overflow;
  logic        w_snap_take;

  assign w_snap_take = w_io_ctl & ~mem_wr;

  // The low snapshot byte goes straight to mem_din, so only the upper three bytes are held.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_counter      <= '0;
      r_snap_hi      <= '0;
      r_program_done <= 1'b0;
      r_tx_overflow  <= 1'b0;
    end else begin
      r_counter <= r_counter + 32'd1;
      if (w_snap_take) begin
        r_snap_hi <= r_counter[31:8];
      end
      if (w_io_ctl & mem_wr) begin
        r_program_done <= 1'b1;
      end
      if (w_tx_drop) begin
        r_tx_overflow <= 1'b1;
      end
    end
  end

  assign program_done = r_program_done;
  assign tx_overflow  = r_tx_overflow;

  // ---------------------------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------------------------
  logic [7:0] w_rd_data;
  logic [7:0] r_mem_din;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_is_ram) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_io_data) begin
      w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
    end else if (w_io_ctl) begin
      w_rd_data = r_counter[7:0];
    end else if (w_io_snap1) begin
      w_rd_data = r_snap_hi[7:0];
    end else if (w_io_snap2) begin
      w_rd_data = r_snap_hi[15:8];
    end else if (w_io_snap3) begin
      w_rd_data = r_snap_hi[23:16];
    end
  end

  // Write cycles leave the last read value on the bus.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mem_din <= 8'h00;
    end else if (!mem_wr) begin
      r_mem_din <= w_rd_data;
    end
  end

  assign mem_din = r_mem_din;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a RAM/decode vector table plus hand-written
// sequences for the TX/RX FIFOs, counter snapshot, sticky flags and mid-traffic reset.
module tb_mem_io_responder;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_done;
  logic        tx_overflow;

  int checks;
  int failures;

  mem_io_responder #(
    .RAM_ADDR_WIDTH(17),
    .TX_DEPTH      (8),
    .RX_DEPTH      (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .program_done  (program_done),
    .tx_overflow   (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Idle bus writes into the hole: no side effects and mem_din is held.
  task automatic bus_idle();
    mem_a    = 32'h0002_0000;
    mem_wr   = 1'b1;
    mem_dout = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] d);
    mem_a  = a;
    mem_wr = 1'b0;
    step();
    d = mem_din;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{32'h0001_FFFF, 1'b1, 8'hA5, 8'h00};
    vecs[1]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'hA5};
    vecs[2]  = '{32'h0000_0000, 1'b1, 8'h3C, 8'hA5};
    vecs[3]  = '{32'h0000_0000, 1'b0, 8'h00, 8'h3C};
    vecs[4]  = '{32'h0001_0000, 1'b1, 8'h77, 8'h3C};
    vecs[5]  = '{32'h0001_0000, 1'b0, 8'h00, 8'h77};
    vecs[6]  = '{32'h0002_0000, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{32'h0002_0001, 1'b1, 8'hFF, 8'h00};
    vecs[8]  = '{32'h0000_0000, 1'b0, 8'h00, 8'h3C};
    vecs[9]  = '{32'h0001_FFFF, 1'b1, 8'h5A, 8'h3C};
    vecs[10] = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h5A};
    vecs[11] = '{32'h0002_ABCD, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{32'hFFF1_FFFF, 1'b0, 8'h00, 8'h5A};
    vecs[13] = '{32'h0003_0008, 1'b0, 8'h00, 8'h00};
    vecs[14] = '{32'h0001_0000, 1'b0, 8'h00, 8'h77};
    vecs[15] = '{32'h0003_0001, 1'b0, 8'h00, 8'h00};

    rst_in   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    bus_idle();
    idle(3);

    check8("reset mem_din", mem_din, 8'h00);
    check1("reset io_buffer_full", io_buffer_full, 1'b0);
    check1("reset tx_valid", tx_valid, 1'b0);
    check1("reset rx_ready", rx_ready, 1'b1);
    check1("reset program_done", program_done, 1'b0);
    check1("reset tx_overflow", tx_overflow, 1'b0);

    // Counter reads 0 before release edge 1, so a snapshot taken at edge N holds N-1.
    rst_in = 1'b0;
    idle(100);
    rd(32'h0003_0004, d); check8("snap b0 @101", d, 8'h64);
    rd(32'h0003_0005, d); check8("snap b1 @101", d, 8'h00);
    rd(32'h0003_0006, d); check8("snap b2 @101", d, 8'h00);
    rd(32'h0003_0007, d); check8("snap b3 @101", d, 8'h00);
    rd(32'h0003_0004, d); check8("snap b0 @105", d, 8'h68);
    idle(300);
    rd(32'h0003_0004, d); check8("snap b0 @406", d, 8'h95);
    rd(32'h0003_0005, d); check8("snap b1 @406", d, 8'h01);
    rd(32'h0003_0006, d); check8("snap b2 @406", d, 8'h00);

    for (int i = 0; i < 16; i++) begin
      mem_a    = vecs[i].a;
      mem_wr   = vecs[i].wr;
      mem_dout = vecs[i].d;
      step();
      checks++;
      if (mem_din !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d a=0x%08h wr=%b: mem_din got 0x%02h expected 0x%02h",
                 i, vecs[i].a, vecs[i].wr, mem_din, vecs[i].exp);
      end
      bus_idle();
    end

    // TX fill with transmitter stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h0003_0000, 8'(8'h41 + i));
      check1("tx fill io_buffer_full", io_buffer_full, (i >= 5));
      check1("tx fill tx_valid", tx_valid, 1'b1);
      check8("tx fill head", tx_data, 8'h41);
      check1("tx fill no overflow", tx_overflow, 1'b0);
    end
    wr(32'h0003_0000, 8'h49);
    check1("tx 9th push overflow", tx_overflow, 1'b1);
    wr(32'h0003_0000, 8'h00);
    check1("tx overflow sticky", tx_overflow, 1'b1);

    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check1("tx drain valid", tx_valid, 1'b1);
      check8("tx drain data", tx_data, 8'(8'h41 + i));
      step();
    end
    check1("tx drained empty", tx_valid, 1'b0);
    check1("tx drained not full", io_buffer_full, 1'b0);

    wr(32'h0003_0004, 8'hEE);
    check1("stop program_done", program_done, 1'b1);
    check1("stop nul valid", tx_valid, 1'b1);
    check8("stop nul data", tx_data, 8'h00);
    step();
    check1("stop nul popped", tx_valid, 1'b0);
    check1("program_done sticky", program_done, 1'b1);

    // RX basic ordering and empty read.
    rx_valid = 1'b1;
    rx_data  = 8'h31; step();
    rx_data  = 8'h32; step();
    rx_valid = 1'b0;
    rd(32'h0003_0000, d); check8("rx pop 1", d, 8'h31);
    rd(32'h0003_0000, d); check8("rx pop 2", d, 8'h32);
    rd(32'h0003_0000, d); check8("rx pop empty", d, 8'h00);

    // Byte pushed into an empty FIFO is not visible to the same-cycle read.
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    rd(32'h0003_0000, d);
    rx_valid = 1'b0;
    check8("rx no bypass", d, 8'h00);
    rd(32'h0003_0000, d); check8("rx after bypass", d, 8'h55);

    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h60 + i);
      step();
      check1("rx fill rx_ready", rx_ready, (i < 7));
    end
    rx_data = 8'h70;
    step();
    rx_valid = 1'b0;
    rd(32'h0003_0000, d); check8("rx pop from full", d, 8'h60);
    check1("rx ready after pop", rx_ready, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'h68;
    rd(32'h0003_0000, d);
    rx_valid = 1'b0;
    check8("rx push+pop data", d, 8'h61);
    check1("rx push+pop occupancy", rx_ready, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'h69;
    step();
    rx_valid = 1'b0;
    check1("rx refilled", rx_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd(32'h0003_0000, d);
      check8("rx drain", d, 8'(8'h62 + i));
    end
    rd(32'h0003_0000, d); check8("rx drained", d, 8'h00);

    // Reset in the middle of traffic.
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h51);
    wr(32'h0003_0000, 8'h52);
    wr(32'h0003_0004, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    step();
    rx_valid = 1'b0;
    rd(32'h0001_FFFF, d); check8("pre-reset ram", d, 8'h5A);
    check1("pre-reset program_done", program_done, 1'b1);
    check1("pre-reset tx_valid", tx_valid, 1'b1);
    check1("pre-reset io_buffer_full", io_buffer_full, 1'b0);
    rst_in = 1'b1;
    step();
    check1("mid reset tx_valid", tx_valid, 1'b0);
    check1("mid reset program_done", program_done, 1'b0);
    check1("mid reset tx_overflow", tx_overflow, 1'b0);
    check8("mid reset mem_din", mem_din, 8'h00);
    rst_in = 1'b0;
    rd(32'h0003_0000, d); check8("rx flushed", d, 8'h00);
    rd(32'h0001_FFFF, d); check8("ram kept", d, 8'h5A);

    // A pop in the same cycle does not make room for a push into a full TX FIFO.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h0003_0000, 8'(8'h80 + i));
    end
    check1("tx full no overflow", tx_overflow, 1'b0);
    check1("tx full io_buffer_full", io_buffer_full, 1'b1);
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h99);
    check1("tx push+pop full overflow", tx_overflow, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check1("tx tail valid", tx_valid, 1'b1);
      check8("tx tail data", tx_data, 8'(8'h81 + i));
      step();
    end
    check1("tx tail empty", tx_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
